// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder block.
// Provides mode/state enums and a width-generic one-hot decode function.
package scan_decoder_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    typedef enum logic {
        S_DIRECT = 1'b0,
        S_SCAN   = 1'b1
    } state_e;

    // Widest index the decode helper supports; callers zero-extend
    // their index and width-cast the result down to their own OUT_W.
    localparam int ONEHOT_MAX_SEL_W = 8;
    localparam int ONEHOT_MAX_OUT_W = 2 ** ONEHOT_MAX_SEL_W;

    function automatic logic [ONEHOT_MAX_OUT_W-1:0] onehot_dec(
        input logic [ONEHOT_MAX_SEL_W-1:0] sel,
        input logic                        en
    );
        logic [ONEHOT_MAX_OUT_W-1:0] w_word;
        w_word = '0;
        if (en)
            w_word[sel] = 1'b1;
        return w_word;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Scan-mode sequencer: dwell counter, dwell latch, rotating index.
// Ports: i_start loads position 0 and latches i_dwell; i_run advances
// the scan; o_idx/o_onehot give the current position; o_wrap pulses
// for one cycle when the index rolls over to 0.
module scan_timer #(
    parameter  int SEL_W   = 3,
    parameter  int DWELL_W = 8,
    localparam int OUT_W   = 2 ** SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_run,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [SEL_W-1:0]   o_idx,
    output logic [OUT_W-1:0]   o_onehot,
    output logic               o_wrap
);

    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell;
    logic [SEL_W-1:0]   r_idx;
    logic [OUT_W-1:0]   r_oh;
    logic               r_wrap;
    logic               w_adv;

    assign w_adv = (r_cnt == r_dwell);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_dwell <= '0;
            r_idx   <= '0;
            r_oh    <= '0;
            r_wrap  <= 1'b0;
        end else if (i_start) begin
            r_cnt   <= '0;
            r_dwell <= i_dwell;
            r_idx   <= '0;
            r_oh    <= OUT_W'(1);
            r_wrap  <= 1'b0;
        end else if (i_run) begin
            if (w_adv) begin
                r_cnt   <= '0;
                r_dwell <= i_dwell;
                r_idx   <= r_idx + SEL_W'(1);
                // Rotating the registered word keeps it one-hot
                // without a decoder in the scan path.
                r_oh    <= {r_oh[OUT_W-2:0], r_oh[OUT_W-1]};
                r_wrap  <= (r_idx == SEL_W'(OUT_W - 1));
            end else begin
                r_cnt   <= r_cnt + DWELL_W'(1);
                r_wrap  <= 1'b0;
            end
        end else begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end
    end

    assign o_idx    = r_idx;
    assign o_onehot = r_oh;
    assign o_wrap   = r_wrap;

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with valid/ready DIRECT mode and
// autonomous rotating SCAN mode. Ports: clk/rst_n (sync, active-low),
// mode, in_valid/in_ready/in_sel/in_en, dwell, out_valid/out_ready,
// d, out_idx, scan_wrap. Optional macro SCAN_DECODER_ONEHOT_CHK_EN
// adds a sticky onehot_err output.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter  int SEL_W   = 3,
    parameter  int DWELL_W = 8,
    localparam int OUT_W   = 2 ** SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   d,
    output logic [SEL_W-1:0]   out_idx,
    output logic               scan_wrap
`ifdef SCAN_DECODER_ONEHOT_CHK_EN
    ,
    output logic               onehot_err
`endif
);

    state_e                      r_state;
    state_e                      w_state_nxt;
    logic                        r_valid;
    logic [OUT_W-1:0]            r_d;
    logic [SEL_W-1:0]            r_idx;
    logic                        w_drain;
    logic                        w_in_ready;
    logic                        w_start;
    logic                        w_run;
    logic                        w_accept;
    logic [ONEHOT_MAX_SEL_W-1:0] w_sel_ext;
    logic [OUT_W-1:0]            w_dec;
    logic [SEL_W-1:0]            w_scan_idx;
    logic [OUT_W-1:0]            w_scan_oh;
    logic                        w_scan_wrap;
    mode_e                       w_mode;

    assign w_mode    = mode_e'(mode);
    assign w_drain   = !r_valid || out_ready;
    assign w_accept  = in_valid && w_in_ready;
    assign w_sel_ext = ONEHOT_MAX_SEL_W'(in_sel);
    assign w_dec     = OUT_W'(onehot_dec(w_sel_ext, in_en));

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_DIRECT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_start     = 1'b0;
        w_run       = 1'b0;
        unique case (r_state)
            S_DIRECT: begin
                if (w_mode == MODE_SCAN) begin
                    // Hold off the switch until the pending word
                    // has been taken so nothing in flight is lost.
                    if (w_drain) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_SCAN;
                    end
                end else begin
                    w_in_ready = w_drain;
                end
            end
            S_SCAN: begin
                if (w_mode == MODE_SCAN)
                    w_run = 1'b1;
                else
                    w_state_nxt = S_DIRECT;
            end
            default: w_state_nxt = S_DIRECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_d     <= '0;
            r_idx   <= '0;
        end else if (r_state == S_SCAN || w_start) begin
            // Parked empty so leaving scan shows out_valid=0, d=0.
            r_valid <= 1'b0;
            r_d     <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_d     <= w_dec;
            r_idx   <= in_sel;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    scan_timer #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_run    (w_run),
        .i_dwell  (dwell),
        .o_idx    (w_scan_idx),
        .o_onehot (w_scan_oh),
        .o_wrap   (w_scan_wrap)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == S_SCAN) ? 1'b1 : r_valid;
    assign d         = (r_state == S_SCAN) ? w_scan_oh : r_d;
    assign out_idx   = (r_state == S_SCAN) ? w_scan_idx : r_idx;
    assign scan_wrap = w_scan_wrap;

`ifdef SCAN_DECODER_ONEHOT_CHK_EN
    logic r_err;
    logic w_multi;
    logic w_scan_zero;

    // x & (x-1) is non-zero exactly when more than one bit is set.
    assign w_multi     = |(d & (d - OUT_W'(1)));
    assign w_scan_zero = (r_state == S_SCAN) && (d == '0);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (w_multi || w_scan_zero)
            r_err <= 1'b1;
    end

    assign onehot_err = r_err;
`endif

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder (SEL_W=3, DWELL_W=8).
// Covers reset, DIRECT sweep, backpressure, enable, SCAN and mode race.
module tb_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_sel;
    logic       in_en;
    logic [7:0] dwell;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] d;
    logic [2:0] out_idx;
    logic       scan_wrap;
`ifdef SCAN_DECODER_ONEHOT_CHK_EN
    logic       onehot_err;
`endif

    int n_vec;
    int n_err;

    logic [7:0] tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                            8'h10, 8'h20, 8'h40, 8'h80};

    scan_decoder #(
        .SEL_W   (3),
        .DWELL_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_en     (in_en),
        .dwell     (dwell),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .out_idx   (out_idx),
        .scan_wrap (scan_wrap)
`ifdef SCAN_DECODER_ONEHOT_CHK_EN
        ,
        .onehot_err (onehot_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'd3;
        in_en     = 1'b1;
        out_ready = 1'b1;
        dwell     = 8'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if ({out_valid, d, out_idx, scan_wrap} !== 13'h0) begin
                n_err++;
                $display("FAIL reset[%0d] got v=%b d=%h idx=%0d w=%b want 0",
                         i, out_valid, d, out_idx, scan_wrap);
            end
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_direct_sweep();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_en     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_sel = 3'(i);
            tick();
            n_vec++;
            if ({out_valid, d, out_idx, in_ready} !==
                {1'b1, tbl[i], 3'(i), 1'b1}) begin
                n_err++;
                $display("FAIL sweep[%0d] got v=%b d=%h idx=%0d rdy=%b want d=%h",
                         i, out_valid, d, out_idx, in_ready, tbl[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_drain got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        in_valid  = 1'b1;
        in_sel    = 3'd5;
        in_en     = 1'b1;
        out_ready = 1'b0;
        tick();
        in_sel = 3'd2;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({out_valid, d, out_idx, in_ready} !==
                {1'b1, 8'h20, 3'd5, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h idx=%0d rdy=%b want d=20 rdy=0",
                         i, out_valid, d, out_idx, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_rdy got %b want 1", in_ready);
        end
        tick();
        n_vec++;
        if ({out_valid, d, out_idx} !== {1'b1, 8'h04, 3'd2}) begin
            n_err++;
            $display("FAIL bp_next got v=%b d=%h idx=%0d want d=04 idx=2",
                     out_valid, d, out_idx);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_enable();
        in_valid  = 1'b1;
        in_sel    = 3'd6;
        in_en     = 1'b0;
        out_ready = 1'b1;
        tick();
        n_vec++;
        if ({out_valid, d, out_idx} !== {1'b1, 8'h00, 3'd6}) begin
            n_err++;
            $display("FAIL enable got v=%b d=%h idx=%0d want v=1 d=00 idx=6",
                     out_valid, d, out_idx);
        end
        in_valid = 1'b0;
        in_en    = 1'b1;
        tick();
    endtask

    task automatic test_scan();
        logic [2:0] e_idx;
        logic       e_wrap;
        int         bad;
        mode      = 1'b1;
        dwell     = 8'd2;
        in_valid  = 1'b1;
        in_sel    = 3'd7;
        out_ready = 1'b0;
        bad       = 0;
        for (int c = 0; c <= 50; c++) begin
            tick();
            e_idx  = 3'((c / 3) % 8);
            e_wrap = (c > 0) && (c % 24 == 0);
            n_vec++;
            if ({out_valid, d, out_idx, scan_wrap, in_ready} !==
                {1'b1, tbl[e_idx], e_idx, e_wrap, 1'b0}) begin
                n_err++;
                bad++;
                if (bad < 6)
                    $display("FAIL scan[%0d] got v=%b d=%h idx=%0d w=%b rdy=%b want d=%h idx=%0d w=%b",
                             c, out_valid, d, out_idx, scan_wrap, in_ready,
                             tbl[e_idx], e_idx, e_wrap);
            end
        end
        in_valid  = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        tick();
        n_vec++;
        if ({out_valid, d, scan_wrap, in_ready} !==
            {1'b0, 8'h00, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL scan_exit got v=%b d=%h w=%b rdy=%b want 0,00,0,1",
                     out_valid, d, scan_wrap, in_ready);
        end
    endtask

    task automatic test_mode_race();
        in_valid  = 1'b1;
        in_sel    = 3'd3;
        in_en     = 1'b1;
        out_ready = 1'b0;
        dwell     = 8'd0;
        tick();
        in_valid = 1'b0;
        mode     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if ({out_valid, d, out_idx, in_ready} !==
                {1'b1, 8'h08, 3'd3, 1'b0}) begin
                n_err++;
                $display("FAIL race_stall[%0d] got v=%b d=%h idx=%0d rdy=%b want d=08 rdy=0",
                         i, out_valid, d, out_idx, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if ({out_valid, d, out_idx} !== {1'b1, 8'h01, 3'd0}) begin
            n_err++;
            $display("FAIL race_entry got v=%b d=%h idx=%0d want d=01 idx=0",
                     out_valid, d, out_idx);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_vec++;
            if ({out_valid, d, out_idx} !== {1'b1, tbl[i], 3'(i)}) begin
                n_err++;
                $display("FAIL race_dwell0[%0d] got d=%h idx=%0d want d=%h",
                         i, d, out_idx, tbl[i]);
            end
        end
        mode = 1'b0;
        tick();
        n_vec++;
        if ({out_valid, d, in_ready} !== {1'b0, 8'h00, 1'b1}) begin
            n_err++;
            $display("FAIL race_exit got v=%b d=%h rdy=%b want 0,00,1",
                     out_valid, d, in_ready);
        end
`ifdef SCAN_DECODER_ONEHOT_CHK_EN
        n_vec++;
        if (onehot_err !== 1'b0) begin
            n_err++;
            $display("FAIL onehot_err got %b want 0", onehot_err);
        end
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_direct_sweep();
        test_backpressure();
        test_enable();
        test_scan();
        test_mode_race();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
